// File: rtl/coin_travel_engine_pkg.sv
// Shared definitions for the coin travel engine: travel codes, waypoints, FSM states.
// Latency: n/a (constants and pure functions only).
// Backpressure: n/a.
package coin_travel_engine_pkg;

  // Leg request codes from the transaction controller
  localparam logic [2:0] TRAVEL_NONE = 3'b000;
  localparam logic [2:0] TRAVEL_1    = 3'b001;
  localparam logic [2:0] TRAVEL_2    = 3'b010;
  localparam logic [2:0] TRAVEL_3    = 3'b011;
  localparam logic [2:0] TRAVEL_4    = 3'b101;

  // Station waypoints on the 160x120 display
  localparam logic [7:0] WP0_X = 8'd8;
  localparam logic [6:0] WP0_Y = 7'd60;
  localparam logic [7:0] WP1_X = 8'd40;
  localparam logic [6:0] WP1_Y = 7'd60;
  localparam logic [7:0] WP2_X = 8'd80;
  localparam logic [6:0] WP2_Y = 7'd20;
  localparam logic [7:0] WP3_X = 8'd120;
  localparam logic [6:0] WP3_Y = 7'd60;
  localparam logic [7:0] WP4_X = 8'd152;
  localparam logic [6:0] WP4_Y = 7'd100;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_LOAD     = 3'd1,
    ST_MOVE     = 3'd2,
    ST_DONE     = 3'd3,
    ST_WAIT_CLR = 3'd4
  } state_t;

  // Start and destination of one latched leg
  typedef struct packed {
    logic [7:0] sx;
    logic [6:0] sy;
    logic [7:0] dx;
    logic [6:0] dy;
  } route_t;

  function automatic logic route_valid(input logic [2:0] code);
    return (code == TRAVEL_1) || (code == TRAVEL_2) ||
           (code == TRAVEL_3) || (code == TRAVEL_4);
  endfunction

  function automatic route_t route_lookup(input logic [2:0] code);
    route_t r;
    case (code)
      TRAVEL_2: r = '{sx: WP1_X, sy: WP1_Y, dx: WP2_X, dy: WP2_Y};
      TRAVEL_3: r = '{sx: WP2_X, sy: WP2_Y, dx: WP3_X, dy: WP3_Y};
      TRAVEL_4: r = '{sx: WP3_X, sy: WP3_Y, dx: WP4_X, dy: WP4_Y};
      default:  r = '{sx: WP0_X, sy: WP0_Y, dx: WP1_X, dy: WP1_Y};
    endcase
    return r;
  endfunction

endpackage

// File: rtl/coin_travel_engine_step_tick_divider.sv
// Step pacing counter: pulses tick_o once every TICKS_PER_STEP enabled cycles.
// Latency: tick_o is combinational from the count, asserted on the last cycle of each period.
// Backpressure: counting pauses while en_i is low; clr_i restarts the period from zero.
module step_tick_divider #(
  parameter int TICKS_PER_STEP = 833333
) (
  input  logic clock,
  input  logic resetn,
  input  logic clr_i,
  input  logic en_i,
  output logic tick_o
);

  localparam int CW = (TICKS_PER_STEP > 1) ? $clog2(TICKS_PER_STEP) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICKS_PER_STEP - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick_o = en_i && (cnt_q == LAST);

  // Next count: clear wins, otherwise advance and wrap on the tick
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + 1'b1;
    end
  end

  // Count register
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/coin_travel_engine.sv
// Moves the coin sprite along fixed waypoint legs and pulses done_travel on arrival.
// Latency: done_travel high in the cycle after edge 2+N*TICKS_PER_STEP from the sampling edge.
// Backpressure: one leg at a time; a held code is ignored until travel returns to 000.
// Build option COIN_TRAVEL_DIAGONAL_EN: step x and y together instead of x-then-y.
module coin_travel_engine
  import coin_travel_engine_pkg::*;
#(
  parameter int TICKS_PER_STEP = 833333,
  parameter int X_W            = 8,
  parameter int Y_W            = 7
) (
  input  logic           clock,
  input  logic           resetn,
  input  logic [2:0]     travel,
  output logic           done_travel,
  output logic [X_W-1:0] coin_x,
  output logic [Y_W-1:0] coin_y,
  output logic           coin_visible,
  output logic           busy
);

  state_t         state_q, state_d;
  route_t         route_q, route_d;
  logic [X_W-1:0] x_q, x_d, x_step, dest_x, start_x;
  logic [Y_W-1:0] y_q, y_d, y_step, dest_y, start_y;
  logic           vis_q, vis_d;
  logic           done_q, done_d;
  logic           div_clr, div_en, tick;
  logic           at_dest;

  assign dest_x  = X_W'(route_q.dx);
  assign dest_y  = Y_W'(route_q.dy);
  assign start_x = X_W'(route_q.sx);
  assign start_y = Y_W'(route_q.sy);
  assign at_dest = (x_q == dest_x) && (y_q == dest_y);

  step_tick_divider #(
    .TICKS_PER_STEP(TICKS_PER_STEP)
  ) u_div (
    .clock (clock),
    .resetn(resetn),
    .clr_i (div_clr),
    .en_i  (div_en),
    .tick_o(tick)
  );

  // One-pixel step toward the destination; never overshoots
  always_comb begin
    x_step = x_q;
    y_step = y_q;
`ifdef COIN_TRAVEL_DIAGONAL_EN
    if (x_q != dest_x) x_step = (x_q < dest_x) ? x_q + 1'b1 : x_q - 1'b1;
    if (y_q != dest_y) y_step = (y_q < dest_y) ? y_q + 1'b1 : y_q - 1'b1;
`else
    if (x_q != dest_x)      x_step = (x_q < dest_x) ? x_q + 1'b1 : x_q - 1'b1;
    else if (y_q != dest_y) y_step = (y_q < dest_y) ? y_q + 1'b1 : y_q - 1'b1;
`endif
  end

  // Leg FSM: latch route, load start, pace steps, pulse done, wait for release
  always_comb begin
    state_d = state_q;
    route_d = route_q;
    x_d     = x_q;
    y_d     = y_q;
    vis_d   = vis_q;
    div_clr = 1'b0;
    div_en  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (route_valid(travel)) begin
          route_d = route_lookup(travel);
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        if (travel == TRAVEL_NONE) begin
          state_d = ST_IDLE;
        end else begin
          x_d     = start_x;
          y_d     = start_y;
          vis_d   = 1'b1;
          div_clr = 1'b1;
          state_d = ST_MOVE;
        end
      end
      ST_MOVE: begin
        if (travel == TRAVEL_NONE) begin
          state_d = ST_IDLE;
        end else if (at_dest) begin
          state_d = ST_DONE;
        end else begin
          div_en = 1'b1;
          if (tick) begin
            x_d = x_step;
            y_d = y_step;
          end
        end
      end
      ST_DONE: state_d = ST_WAIT_CLR;
      ST_WAIT_CLR: begin
        if (travel == TRAVEL_NONE) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign done_d = (state_d == ST_DONE);

  // State, route, position and registered done pulse
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      route_q <= '0;
      x_q     <= X_W'(WP0_X);
      y_q     <= Y_W'(WP0_Y);
      vis_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      route_q <= route_d;
      x_q     <= x_d;
      y_q     <= y_d;
      vis_q   <= vis_d;
      done_q  <= done_d;
    end
  end

  assign done_travel  = done_q;
  assign coin_x       = x_q;
  assign coin_y       = y_q;
  assign coin_visible = vis_q;
  assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_coin_travel_engine.sv
// Bench for coin_travel_engine: reference model of leg timing and path, plus directed and random stimulus.
// Runs with TICKS_PER_STEP=2.
// Honors COIN_TRAVEL_DIAGONAL_EN for expected step counts.
module tb_coin_travel_engine;

  localparam int T = 2;

  logic       clock = 1'b0;
  logic       resetn = 1'b0;
  logic [2:0] travel = 3'b000;
  logic       done_travel;
  logic [7:0] coin_x;
  logic [6:0] coin_y;
  logic       coin_visible;
  logic       busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clock = ~clock;

  coin_travel_engine #(
    .TICKS_PER_STEP(T),
    .X_W(8),
    .Y_W(7)
  ) dut (
    .clock       (clock),
    .resetn      (resetn),
    .travel      (travel),
    .done_travel (done_travel),
    .coin_x      (coin_x),
    .coin_y      (coin_y),
    .coin_visible(coin_visible),
    .busy        (busy)
  );

  // ---------------- reference model ----------------
  int wx[5] = '{8, 40, 80, 120, 152};
  int wy[5] = '{60, 60, 20, 60, 100};

  function automatic int start_idx(input logic [2:0] c);
    case (c)
      3'b001: return 0;
      3'b010: return 1;
      3'b011: return 2;
      3'b101: return 3;
      default: return -1;
    endcase
  endfunction

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  function automatic int isgn(input int v);
    return (v > 0) ? 1 : ((v < 0) ? -1 : 0);
  endfunction

  function automatic int leg_len(input int s);
    int ax, ay;
    ax = iabs(wx[s+1] - wx[s]);
    ay = iabs(wy[s+1] - wy[s]);
`ifdef COIN_TRAVEL_DIAGONAL_EN
    return (ax > ay) ? ax : ay;
`else
    return ax + ay;
`endif
  endfunction

  // Position after k steps along leg s
  function automatic void leg_pos(input int s, input int k, output int x, output int y);
    int dx, dy, ax, ay;
    dx = wx[s+1] - wx[s];
    dy = wy[s+1] - wy[s];
    ax = iabs(dx);
    ay = iabs(dy);
`ifdef COIN_TRAVEL_DIAGONAL_EN
    x = wx[s] + isgn(dx) * ((k < ax) ? k : ax);
    y = wy[s] + isgn(dy) * ((k < ay) ? k : ay);
`else
    if (k <= ax) begin
      x = wx[s] + isgn(dx) * k;
      y = wy[s];
    end else begin
      x = wx[s+1];
      y = wy[s] + isgn(dy) * (((k - ax) < ay) ? (k - ax) : ay);
    end
`endif
  endfunction

  // phase: 0 idle, 1 on a leg (load/move), 2 arrival cycle, 3 waiting for release
  int m_phase = 0, m_edge = 0, m_route = 0, m_x = 8, m_y = 60;
  bit m_vis = 1'b0, m_done = 1'b0;

  always @(posedge clock) begin : model_and_compare
    logic [2:0]  c;
    int          n, steps;
    logic [17:0] exp_v, act_v;
    c = travel;
    if (!resetn) begin
      m_phase = 0; m_x = 8; m_y = 60; m_vis = 1'b0; m_done = 1'b0;
    end else begin
      case (m_phase)
        0: begin
          m_done = 1'b0;
          if (start_idx(c) >= 0) begin
            m_phase = 1; m_route = start_idx(c); m_edge = 0;
          end
        end
        1: begin
          m_edge++;
          n = leg_len(m_route);
          if (c == 3'b000) begin
            m_phase = 0;
          end else if (m_edge == 1) begin
            leg_pos(m_route, 0, m_x, m_y);
            m_vis = 1'b1;
          end else if (m_edge == 2 + n * T) begin
            m_phase = 2; m_done = 1'b1;
          end else begin
            steps = (m_edge - 1) / T;
            if (steps > n) steps = n;
            leg_pos(m_route, steps, m_x, m_y);
          end
        end
        2: begin
          m_done = 1'b0; m_phase = 3;
        end
        default: begin
          if (c == 3'b000) m_phase = 0;
        end
      endcase
    end
    #1;
    exp_v = {8'(m_x), 7'(m_y), m_vis, m_done, (m_phase != 0)};
    act_v = {coin_x, coin_y, coin_visible, done_travel, busy};
    n_cmp++;
    if (act_v !== exp_v) begin
      n_bad++;
      $display("FAIL model_cycle t=%0t: x/y/vis/done/busy got %0d/%0d/%b/%b/%b expected %0d/%0d/%b/%b/%b",
               $time, coin_x, coin_y, coin_visible, done_travel, busy,
               m_x, m_y, m_vis, m_done, (m_phase != 0));
    end
  end

  // ---------------- literal checks and stimulus ----------------
  task automatic check(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive a code and observe for a fixed number of edges (edge 0 = first edge after drive)
  task automatic hold_code(input logic [2:0] code, input int cycles, output int first, output int pulses);
    @(negedge clock);
    travel = code;
    first  = -1;
    pulses = 0;
    for (int i = 0; i < cycles; i++) begin
      @(posedge clock);
      #1;
      if (done_travel) begin
        pulses++;
        if (first < 0) first = i;
      end
    end
  endtask

  initial begin
    int f, p, x1, y1;
    bit order_bad;
    int exp_n2;
    logic [2:0] code;
    int dur;

`ifdef COIN_TRAVEL_DIAGONAL_EN
    exp_n2 = 40;
`else
    exp_n2 = 80;
`endif

    // Reset state
    resetn = 1'b0;
    repeat (3) @(negedge clock);
    check("rst_x", coin_x, 8);
    check("rst_y", coin_y, 60);
    check("rst_vis", coin_visible, 0);
    check("rst_done", done_travel, 0);
    check("rst_busy", busy, 0);
    resetn = 1'b1;

    // Leg 001 held well past arrival: exactly one pulse at edge 66
    hold_code(3'b001, 90, f, p);
    check("leg1_done_edge", f, 2 + 32 * T);
    check("leg1_pulses", p, 1);
    check("leg1_x", coin_x, 40);
    check("leg1_y", coin_y, 60);
    check("leg1_vis", coin_visible, 1);
    hold_code(3'b000, 2, f, p);
    check("leg1_busy_clr", busy, 0);

    // Leg 010: x reaches 80 before y moves (x-then-y build)
    @(negedge clock);
    travel = 3'b010;
    f = -1;
    order_bad = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (coin_y != 7'd60 && coin_x != 8'd80) order_bad = 1'b1;
      if (done_travel && f < 0) f = i;
    end
    check("leg2_done_edge", f, 2 + exp_n2 * T);
`ifndef COIN_TRAVEL_DIAGONAL_EN
    check("leg2_x_first", order_bad, 0);
`endif
    check("leg2_x", coin_x, 80);
    check("leg2_y", coin_y, 20);
    hold_code(3'b000, 2, f, p);

    // Leg 011 aborted after 10 edges: frozen at 4 steps, no pulse
    hold_code(3'b011, 10, f, p);
    @(negedge clock);
    travel = 3'b000;
    repeat (3) @(posedge clock);
    #1;
    check("abort_pulses", p + int'(done_travel), 0);
    check("abort_busy", busy, 0);
    check("abort_x", coin_x, 84);
`ifdef COIN_TRAVEL_DIAGONAL_EN
    check("abort_y", coin_y, 24);
`else
    check("abort_y", coin_y, 20);
`endif

    // Restart 011: reloads from (80,20) and completes
    @(negedge clock);
    travel = 3'b011;
    f = -1;
    x1 = -1;
    y1 = -1;
    for (int i = 0; i < 200; i++) begin
      @(posedge clock);
      #1;
      if (i == 1) begin
        x1 = coin_x;
        y1 = coin_y;
      end
      if (done_travel && f < 0) f = i;
    end
    check("restart_x", x1, 80);
    check("restart_y", y1, 20);
    check("leg3_done_edge", f, 2 + exp_n2 * T);
    check("leg3_x", coin_x, 120);
    check("leg3_y", coin_y, 60);
    hold_code(3'b000, 2, f, p);

    // Invalid code: stays idle
    hold_code(3'b110, 6, f, p);
    check("inv_busy", busy, 0);
    check("inv_pulses", p, 0);
    hold_code(3'b000, 2, f, p);

    // Random codes, hold lengths and occasional resets; model checks every cycle
    for (int seg = 0; seg < 50; seg++) begin
      if ($urandom_range(0, 11) == 0) begin
        @(negedge clock);
        resetn = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
      end
      code = 3'($urandom_range(0, 7));
      dur  = int'($urandom_range(1, 180));
      @(negedge clock);
      travel = code;
      repeat (dur) @(negedge clock);
    end
    travel = 3'b000;
    repeat (4) @(negedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
